speed_ctrl: RTL and testbench

- Upstream stage of the lane-stripe mover: converts the keyboard keycode into the per-frame scroll speed `diff` (0..3) that the lanes block consumes.
- Sequential ramp: holding accelerate raises speed one step per ACCEL_FRAMES frames. Brake lowers it faster. Releasing all keys coasts the speed down to rest.
- Runs on frame_clk, one update per video frame.

---
 rtl/hp_pkg.sv | 18 +
 rtl/speed_ctrl.sv | 100 ++++++++++
 tb/tb_speed_ctrl.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/hp_pkg.sv
// Shared types and constants for the lane-stripe mover and its speed stage.
package hp_pkg;

  localparam int unsigned SPEED_W = 2;
  localparam int unsigned KEY_W   = 8;
  localparam int unsigned DIFF_W  = 11;

  localparam logic [KEY_W-1:0] DEF_KEY_ACCEL = 8'h1A;
  localparam logic [KEY_W-1:0] DEF_KEY_BRAKE = 8'h16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCEL = 2'd1,
    BRAKE = 2'd2,
    COAST = 2'd3
  } speed_state_t;

endpackage

// File: rtl/speed_ctrl.sv
// Keycode-driven scroll speed ramp feeding the lanes block, one update per frame.
// Optional distance accumulator enabled by defining SPEED_CTRL_ODOMETER_EN.
module speed_ctrl
  import hp_pkg::*;
#(
  parameter logic [KEY_W-1:0] KEY_ACCEL    = DEF_KEY_ACCEL,
  parameter logic [KEY_W-1:0] KEY_BRAKE    = DEF_KEY_BRAKE,
  parameter int unsigned      MAX_SPEED    = 3,
  parameter int unsigned      ACCEL_FRAMES = 30,
  parameter int unsigned      BRAKE_FRAMES = 8,
  parameter int unsigned      COAST_FRAMES = 60
) (
  input  logic              frame_clk,
  input  logic              Reset,
  input  logic [KEY_W-1:0]  keycode,
  output logic [DIFF_W-1:0] diff,
  output logic              moving,
  output logic [2:0]        state_dbg,
  output logic [15:0]       odometer
);

  localparam logic [SPEED_W-1:0] SPEED_TOP  = SPEED_W'(MAX_SPEED);
  localparam logic [7:0]         ACCEL_LAST = 8'(ACCEL_FRAMES - 1);
  localparam logic [7:0]         BRAKE_LAST = 8'(BRAKE_FRAMES - 1);
  localparam logic [7:0]         COAST_LAST = 8'(COAST_FRAMES - 1);

  speed_state_t       state, state_next;
  logic [SPEED_W-1:0] speed, speed_next;
  logic [7:0]         cnt, cnt_next;
  logic               acc, brk;

  always_ff @(posedge frame_clk) begin
    if (Reset) begin
      state <= IDLE;
      speed <= '0;
      cnt   <= '0;
    end else begin
      state <= state_next;
      speed <= speed_next;
      cnt   <= cnt_next;
    end
  end

  always_comb begin
    acc        = (keycode == KEY_ACCEL);
    brk        = (keycode == KEY_BRAKE);
    state_next = state;
    speed_next = speed;
    cnt_next   = cnt;

    if (brk)             state_next = BRAKE;
    else if (acc)        state_next = ACCEL;
    else if (speed == 0) state_next = IDLE;
    else                 state_next = COAST;

    // Any state change discards partial frame progress; speed only moves while dwelling.
    if (state_next != state) begin
      cnt_next = '0;
    end else begin
      unique case (state)
        ACCEL: begin
          if (speed == SPEED_TOP)       cnt_next = '0;
          else if (cnt == ACCEL_LAST) begin
            speed_next = speed + 1'b1;
            cnt_next   = '0;
          end else                      cnt_next = cnt + 1'b1;
        end
        BRAKE, COAST: begin
          if (speed == 0)               cnt_next = '0;
          else if (cnt == ((state == BRAKE) ? BRAKE_LAST : COAST_LAST)) begin
            speed_next = speed - 1'b1;
            cnt_next   = '0;
          end else                      cnt_next = cnt + 1'b1;
        end
        default:                        cnt_next = '0;
      endcase
    end
  end

  assign diff      = {{(DIFF_W - SPEED_W){1'b0}}, speed};
  assign moving    = (speed != '0);
  assign state_dbg = {1'b0, state};

`ifdef SPEED_CTRL_ODOMETER_EN
  logic [15:0] odo_q;
  logic [16:0] odo_sum;

  assign odo_sum = {1'b0, odo_q} + 17'(speed);

  always_ff @(posedge frame_clk) begin
    if (Reset) odo_q <= '0;
    else       odo_q <= odo_sum[16] ? '1 : odo_sum[15:0];
  end

  assign odometer = odo_q;
`else
  assign odometer = '0;
`endif

endmodule

// File: tb/tb_speed_ctrl.sv
// Table-driven scoreboard bench for speed_ctrl; expected values come from the ramp timing rules.
module tb_speed_ctrl;

  localparam logic [7:0] K_A = 8'h1A;
  localparam logic [7:0] K_B = 8'h16;
  localparam logic [7:0] K_X = 8'h04;
  localparam logic [2:0] S_I = 3'd0;
  localparam logic [2:0] S_A = 3'd1;
  localparam logic [2:0] S_B = 3'd2;
  localparam logic [2:0] S_C = 3'd3;

  typedef struct {
    logic        rst;
    logic [7:0]  key;
    int unsigned n;
    logic [1:0]  spd;
    logic [2:0]  st;
    logic        odo_chk;
    logic [15:0] odo;
  } vec_t;

  typedef struct {
    int unsigned idx;
    logic [1:0]  spd;
    logic [2:0]  st;
    logic        odo_chk;
    logic [15:0] odo;
  } exp_t;

  logic        frame_clk = 1'b0;
  logic        Reset     = 1'b1;
  logic [7:0]  keycode   = '0;
  logic [10:0] diff;
  logic        moving;
  logic [2:0]  state_dbg;
  logic [15:0] odometer;

  int unsigned n_total = 0;
  int unsigned n_pass  = 0;

  vec_t vecs[$];
  exp_t exp_q[$];

  speed_ctrl dut (
    .frame_clk (frame_clk),
    .Reset     (Reset),
    .keycode   (keycode),
    .diff      (diff),
    .moving    (moving),
    .state_dbg (state_dbg),
    .odometer  (odometer)
  );

  always #5 frame_clk = ~frame_clk;

  task automatic chk(input string name, input int unsigned idx,
                     input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s row %0d: got %0h, expected %0h", name, idx, act, req);
  endtask

  task automatic add(input logic rst, input logic [7:0] key, input int unsigned n,
                     input logic [1:0] spd, input logic [2:0] st,
                     input logic odo_chk = 1'b0, input logic [15:0] odo = '0);
    vecs.push_back('{rst, key, n, spd, st, odo_chk, odo});
  endtask

  initial begin
    exp_t e;

    // Reset and accel ramp: entry edge 0, steps at edges 30/60/90, held to edge 200.
    add(1, 8'h00,   2, 0, S_I, 1, 16'd0);
    add(0, K_A,     1, 0, S_A);
    add(0, K_A,    29, 0, S_A);
    add(0, K_A,     1, 1, S_A);
    add(0, K_A,    29, 1, S_A);
    add(0, K_A,     1, 2, S_A);
    add(0, K_A,    30, 3, S_A);
    add(0, K_A,   110, 3, S_A, 1, 16'd420);
    // Coast from 3: steps at +60/+120/+180, IDLE one edge later.
    add(0, 8'h00,   1, 3, S_C);
    add(0, 8'h00,  59, 3, S_C);
    add(0, 8'h00,   1, 2, S_C);
    add(0, 8'h00,  60, 1, S_C);
    add(0, 8'h00,  60, 0, S_C);
    add(0, 8'h00,   1, 0, S_I);
    // Back to top speed, then brake: steps at +8/+16/+24, then holds at 0.
    add(0, K_A,    91, 3, S_A);
    add(0, K_B,     1, 3, S_B);
    add(0, K_B,     7, 3, S_B);
    add(0, K_B,     1, 2, S_B);
    add(0, K_B,     8, 1, S_B);
    add(0, K_B,     8, 0, S_B);
    add(0, K_B,    20, 0, S_B);
    // Partial accel progress discarded by a one-edge brake blip.
    add(0, K_A,    31, 1, S_A);
    add(0, K_B,     1, 1, S_B);
    add(0, K_A,    29, 1, S_A);
    add(0, K_B,     1, 1, S_B);
    add(0, K_A,    30, 1, S_A);
    add(0, K_A,     1, 2, S_A);
    // Unrecognised keycode behaves as no key.
    add(0, K_X,     1, 2, S_C);
    add(0, K_A,     1, 2, S_A);
    // Reset while accelerating wins; ramp restarts after release.
    add(1, K_A,     1, 0, S_I, 1, 16'd0);
    add(0, K_A,     1, 0, S_A, 1, 16'd0);
    add(0, K_A,    29, 0, S_A);
    add(0, K_A,     1, 1, S_A);
    // Long hold at top speed: odometer saturates and stays saturated.
    add(0, K_A, 22000, 3, S_A, 1, 16'hFFFF);
    add(0, K_A,   100, 3, S_A, 1, 16'hFFFF);

    foreach (vecs[i]) begin
      @(negedge frame_clk);
      Reset   = vecs[i].rst;
      keycode = vecs[i].key;
      exp_q.push_back('{i, vecs[i].spd, vecs[i].st, vecs[i].odo_chk, vecs[i].odo});
      repeat (vecs[i].n) @(posedge frame_clk);
      #1;
      e = exp_q.pop_front();
      chk("diff",      e.idx, 32'(diff),      32'({9'b0, e.spd}));
      chk("moving",    e.idx, 32'(moving),    32'(e.spd != 2'd0));
      chk("state_dbg", e.idx, 32'(state_dbg), 32'(e.st));
`ifdef SPEED_CTRL_ODOMETER_EN
      if (e.odo_chk) chk("odometer", e.idx, 32'(odometer), 32'(e.odo));
`else
      chk("odometer", e.idx, 32'(odometer), 32'h0);
`endif
    end

    // Hand sequence: coast from rest never leaves IDLE and moving stays low.
    @(negedge frame_clk);
    Reset   = 1'b1;
    keycode = 8'h00;
    @(posedge frame_clk);
    @(negedge frame_clk);
    Reset = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(posedge frame_clk);
      #1;
      chk("idle_state",  100 + k, 32'(state_dbg), 32'(S_I));
      chk("idle_moving", 100 + k, 32'(moving),    32'h0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
